// File: rtl/pipe_stage_buf.sv
// Pipeline boundary register with valid/ready handshake, optional 2-entry skid buffer,
// flush that keeps a PC on the resulting bubble, and a saturating bubble counter.
module pipe_stage_buf #(
   parameter int unsigned WIDTH = 160,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned SKID  = 1,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [PC_W-1:0]  out_pc,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic             m_valid, m_valid_nx;
   logic [WIDTH-1:0] m_data, m_data_nx;
   logic [PC_W-1:0]  m_pc, m_pc_nx;
   logic [WIDTH-1:0] s_data, s_data_nx;
   logic [PC_W-1:0]  s_pc, s_pc_nx;
   logic             rdy_q, rdy_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             take_in;
   logic             take_out;

   // With the skid buffer in_ready is a flop; without it, it is the classic pass-through ready.
   assign in_ready = (SKID != 0) ? rdy_q : (out_ready || !m_valid);
   assign take_in  = in_valid && in_ready;
   assign take_out = m_valid && out_ready;

   assign out_valid  = m_valid;
   assign out_data   = m_data;
   assign out_pc     = m_pc;
   assign bubble_cnt = cnt;

   // Next-state for main/skid registers, ready flop and bubble counter.
   always_comb begin
      state_nx   = state;
      m_valid_nx = m_valid;
      m_data_nx  = m_data;
      m_pc_nx    = m_pc;
      s_data_nx  = s_data;
      s_pc_nx    = s_pc;
      cnt_nx     = cnt;

      if (!m_valid && out_ready && (cnt != CNT_MAX)) begin
         cnt_nx = cnt + CNT_W'(1);
      end

      if (clr) begin
         // Flush: zeroed payload decodes as "no write"; the bubble still carries a PC.
         state_nx   = EMPTY;
         m_valid_nx = 1'b0;
         m_data_nx  = '0;
         if (in_valid) begin
            m_pc_nx = in_pc;
         end
         s_data_nx  = '0;
         s_pc_nx    = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (take_in) begin
                  m_valid_nx = 1'b1;
                  m_data_nx  = in_data;
                  m_pc_nx    = in_pc;
                  state_nx   = ONE;
               end
            end
            ONE: begin
               if (take_in && take_out) begin
                  m_data_nx = in_data;
                  m_pc_nx   = in_pc;
               end else if (take_in) begin
                  s_data_nx = in_data;
                  s_pc_nx   = in_pc;
                  state_nx  = FULL;
               end else if (take_out) begin
                  m_valid_nx = 1'b0;
                  m_data_nx  = '0;
                  state_nx   = EMPTY;
               end
            end
            FULL: begin
               if (take_out) begin
                  m_data_nx = s_data;
                  m_pc_nx   = s_pc;
                  s_data_nx = '0;
                  s_pc_nx   = '0;
                  state_nx  = ONE;
               end
            end
            default: begin
               state_nx   = EMPTY;
               m_valid_nx = 1'b0;
               m_data_nx  = '0;
            end
         endcase
      end

      rdy_nx = (state_nx != FULL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= EMPTY;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_pc    <= '0;
         s_data  <= '0;
         s_pc    <= '0;
         rdy_q   <= 1'b1;
         cnt     <= '0;
      end else begin
         state   <= state_nx;
         m_valid <= m_valid_nx;
         m_data  <= m_data_nx;
         m_pc    <= m_pc_nx;
         s_data  <= s_data_nx;
         s_pc    <= s_pc_nx;
         rdy_q   <= rdy_nx;
         cnt     <= cnt_nx;
      end
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed ID/EX-style stage register.
- Carries an opaque payload plus a PC field across one pipeline boundary.
- Adds a valid/ready handshake and a 2-entry skid buffer, so upstream ready is fully registered.
- Adds flush with PC retention, so bubbles keep a PC, and a saturating bubble counter for perf monitoring.
- One instance per boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), each with its own WIDTH.

Parameters:
- WIDTH, 160, payload bits: control plus data fields concatenated by the instantiating stage.
- PC_W, 32, PC field width.
- SKID, 1, 1 = 2-entry skid buffer; 0 = single register, with in_ready combinational (= out_ready || !out_valid).
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; highest priority.
- clr  in  1  synchronous flush: converts stage contents to bubbles.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts this cycle.
- in_data  in  WIDTH  upstream payload.
- in_pc  in  PC_W  upstream PC.
- out_valid  out  1  out_data/out_pc hold a real instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  registered payload.
- out_pc  out  PC_W  registered PC (meaningful even on bubbles).
- bubble_cnt  out  CNT_W  saturating count of bubble cycles.

Behaviour:
- Clock, reset and handshake:
  - One clock; reset is synchronous and active-high.
  - Priority per edge: reset > clr > handshake.
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - All outputs come straight from registers; no combinational in->out path when SKID=1.
- Reset:
  - out_valid=0, out_data=0, out_pc=0, skid entry invalid and zeroed.
  - in_ready=1 from the first edge after reset deasserts (held 1 during reset); bubble_cnt=0.
- State (SKID=1), in terms of main (output) register M and skid register S:
  - EMPTY: M invalid. ONE: M valid, S invalid. FULL: M and S valid.
  - in_ready is registered: in_ready = !S.valid.
- EMPTY:
  - Transfer in -> M <= in, go to ONE.
  - Otherwise stay EMPTY.
- ONE:
  - in and out together -> M <= in, stay ONE.
  - in only (out_ready=0) -> S <= in, go to FULL; in_ready falls next cycle.
  - out only -> go to EMPTY.
  - Neither -> hold.
- FULL:
  - out_ready=1 -> M <= S, S cleared, go to ONE.
  - No transfer in is possible (in_ready=0).
- Latency and throughput:
  - Latency is 1 cycle, in -> out_valid.
  - Sustained throughput 1/cycle with out_ready held high.
  - No payload is dropped or duplicated under any out_ready pattern.
- clr (flush), not coincident with reset:
  - M and S invalidated; out_data <= 0.
  - out_pc <= in_pc when in_valid, else out_pc holds.
  - State -> EMPTY; in_ready=1 next cycle.
  - Any in transfer in the clr cycle is discarded.
  - clr on the same edge as an out transfer: the out transfer still counts downstream; the contents are then flushed.
- Bubble semantics:
  - When out_valid=0, out_data is all-zero, so every control field decodes as "no write".
  - Downstream may rely on this without checking out_valid.
- bubble_cnt:
  - Increments on each edge where out_valid=0 && out_ready=1, i.e. the downstream slot was wasted.
  - Saturates at 2^CNT_W−1, no wrap; cleared only by reset, not by clr.
- SKID=0:
  - S is absent; in_ready = out_ready || !out_valid.
  - Otherwise identical, including clr and bubble rules.
- Reset mid-operation (FULL with stalled output): next edge gives all outputs at reset values; both entries are lost.

Test Plan:
- Streaming:
  - Stimulus: reset 2 cycles, then in_valid=1 and out_ready=1 every cycle, data 1..8, pc 0x3000+4k.
  - Required: out_data 1..8 on consecutive cycles, 1 cycle behind input; in_ready=1 throughout; bubble_cnt=1, from the first empty slot.
- Backpressure and skid:
  - Stimulus: send A then B with out_ready=0.
  - Required: A in M, B in S, in_ready=0 from the cycle after B.
  - Then out_ready=1: A then B on consecutive cycles; in_ready returns to 1 one cycle after A leaves.
- Flush keeps PC:
  - Stimulus: FULL with A (pc 0x3004) and B; assert clr with in_valid=1, in_pc=0x3010, data C.
  - Required next cycle: out_valid=0, out_data=0, out_pc=0x3010, in_ready=1; C never appears at the output.
- Reset priority:
  - Stimulus: assert reset and clr together while FULL.
  - Required: all outputs 0, bubble_cnt=0, in_ready=1 once reset drops.
- Counter saturation:
  - Stimulus: CNT_W=4, idle with out_ready=1 for 20 cycles.
  - Required: bubble_cnt reaches 15 and holds; a subsequent clr leaves it at 15.
- SKID=0 instance:
  - Stimulus: stalled out_ready=0 with out_valid=1.
  - Required: in_ready=0 in the same cycle; when out_ready rises, in_ready=1 combinationally and the new data loads on that edge.
